// File: rtl/dcwbuf.sv
// Data-cache write buffer: in-order store FIFO with byte forwarding to younger loads.
// Define DCWBUF_MERGE_EN to merge cacheable stores into a matching, non-head tail entry.
module dcwbuf #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Paw   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sbvalid_i,
  output logic                   sbready_o,
  input  logic [Paw-1:0]         sbpa_i,
  input  logic [63:0]            sbdata_i,
  input  logic [2:0]             sbsz_i,
  input  logic                   sbcache_i,
  output logic                   dcwrite_o,
  output logic [Paw-1:0]         dcpa_o,
  output logic [63:0]            dcwdata_o,
  output logic [7:0]             dcmask_o,
  output logic                   dccache_o,
  input  logic                   dcbusy_i,
  input  logic                   ldvalid_i,
  input  logic [Paw-1:0]         ldpa_i,
  input  logic [2:0]             ldsz_i,
  input  logic                   ldcache_i,
  output logic                   ldhit_o,
  output logic [63:0]            lddata_o,
  output logic                   ldconflict_o,
  input  logic                   sbflush_i,
  output logic                   sbempty_o,
  output logic [$clog2(Depth):0] sbcount_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  // Lanes off..off+sz; lanes past 7 are dropped rather than wrapped.
  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [2:0] sz);
    logic [3:0] last;
    logic [7:0] m;
    last = {1'b0, off} + {1'b0, sz};
    for (int k = 0; k < 8; k++) begin
      m[k] = (4'(k) >= {1'b0, off}) && (4'(k) <= last);
    end
    return m;
  endfunction

  function automatic logic [63:0] lane_bits(input logic [7:0] m);
    logic [63:0] b;
    for (int k = 0; k < 8; k++) begin
      b[8*k +: 8] = {8{m[k]}};
    end
    return b;
  endfunction

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] cache_q;
  logic [Paw-4:0]   pa_q   [Depth];
  logic [63:0]      data_q [Depth];
  logic [7:0]       mask_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic        empty, full, enq, alloc, pop, merge_ok;
  logic [7:0]  sb_mask;
  logic [63:0] sb_bits, sb_wdata;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign sb_mask  = lane_mask(sbpa_i[2:0], sbsz_i);
  assign sb_bits  = lane_bits(sb_mask);
  assign sb_wdata = sbdata_i & sb_bits;

`ifdef DCWBUF_MERGE_EN
  logic [PtrW-1:0] tail_last;
  logic            merge;
  assign tail_last = tail_q - PtrW'(1);
  // count >= 2 keeps the merge target away from the entry being presented to the cache.
  assign merge_ok  = sbcache_i && cache_q[tail_last] && (pa_q[tail_last] == sbpa_i[Paw-1:3])
                     && (count_q >= CntW'(2));
  assign merge     = enq && merge_ok;
`else
  assign merge_ok  = 1'b0;
`endif

  assign sbready_o = (!full || merge_ok) && !sbflush_i;
  assign enq       = sbvalid_i && sbready_o;
  assign alloc     = enq && !merge_ok;
  assign pop       = !empty && !dcbusy_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      head_d          = head_q + PtrW'(1);
      valid_d[head_q] = 1'b0;
    end
    if (alloc) begin
      tail_d          = tail_q + PtrW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (alloc && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !alloc) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      cache_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        pa_q[i]   <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      if (alloc) begin
        pa_q[tail_q]    <= sbpa_i[Paw-1:3];
        data_q[tail_q]  <= sb_wdata;
        mask_q[tail_q]  <= sb_mask;
        cache_q[tail_q] <= sbcache_i;
      end
`ifdef DCWBUF_MERGE_EN
      if (merge) begin
        mask_q[tail_last] <= mask_q[tail_last] | sb_mask;
        data_q[tail_last] <= (data_q[tail_last] & ~sb_bits) | sb_wdata;
      end
`endif
    end
  end

  assign dcwrite_o = !empty;
  assign dcpa_o    = {pa_q[head_q], 3'b000};
  assign dcwdata_o = data_q[head_q];
  assign dcmask_o  = empty ? 8'h00 : mask_q[head_q];
  assign dccache_o = cache_q[head_q];
  assign sbempty_o = empty;
  assign sbcount_o = count_q;

  logic [7:0]      ld_req, ld_cov;
  logic [63:0]     ld_fwd;
  logic            ld_nc;
  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so later writers overwrite earlier lanes.
  always_comb begin
    ld_req = lane_mask(ldpa_i[2:0], ldsz_i);
    ld_cov = '0;
    ld_fwd = '0;
    ld_nc  = 1'b0;
    idx    = '0;
    for (int i = 0; i < Depth; i++) begin
      idx = head_q + PtrW'(i);
      if (valid_q[idx] && (pa_q[idx] == ldpa_i[Paw-1:3])) begin
        ld_cov = ld_cov | mask_q[idx];
        ld_fwd = (ld_fwd & ~lane_bits(mask_q[idx])) | data_q[idx];
        if (!cache_q[idx]) ld_nc = 1'b1;
      end
    end
  end

  assign ldhit_o      = ldvalid_i && ldcache_i && ((ld_req & ~ld_cov) == 8'h00);
  assign ldconflict_o = ldvalid_i && ((((ld_req & ld_cov) != 8'h00) && ((ld_req & ~ld_cov) != 8'h00))
                        || (!ldcache_i && !empty) || ld_nc);
  assign lddata_o     = ldvalid_i ? ld_fwd : 64'h0;

endmodule

// File: tb/tb_dcwbuf.sv
// Bench for dcwbuf: queue-based reference model, drain scoreboard and lookup checks.
// Define DCWBUF_MERGE_EN here too when building the merging variant.
module tb_dcwbuf;
  localparam int DEPTH = 4;
  localparam int PAW   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sbvalid, sbready, sbcache, dcwrite, dccache, dcbusy;
  logic        ldvalid, ldcache, ldhit, ldconflict, sbflush, sbempty;
  logic [31:0] sbpa, dcpa, ldpa;
  logic [63:0] sbdata, dcwdata, lddata;
  logic [2:0]  sbsz, ldsz;
  logic [7:0]  dcmask;
  logic [$clog2(DEPTH):0] sbcount;

  always #5 clk = ~clk;

  dcwbuf #(.Depth(DEPTH), .Paw(PAW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sbvalid_i(sbvalid), .sbready_o(sbready), .sbpa_i(sbpa), .sbdata_i(sbdata),
    .sbsz_i(sbsz), .sbcache_i(sbcache),
    .dcwrite_o(dcwrite), .dcpa_o(dcpa), .dcwdata_o(dcwdata), .dcmask_o(dcmask),
    .dccache_o(dccache), .dcbusy_i(dcbusy),
    .ldvalid_i(ldvalid), .ldpa_i(ldpa), .ldsz_i(ldsz), .ldcache_i(ldcache),
    .ldhit_o(ldhit), .lddata_o(lddata), .ldconflict_o(ldconflict),
    .sbflush_i(sbflush), .sbempty_o(sbempty), .sbcount_o(sbcount)
  );

  typedef struct packed {
    logic [28:0] dw;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        cache;
  } ent_t;

  ent_t mq[$];   // model buffer contents, oldest first
  ent_t sbq[$];  // expected cache writes, popped by the monitor
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] lanes(input logic [2:0] off, input logic [2:0] sz);
    bit [7:0] m = 0;
    for (int k = int'(off); k <= int'(off) + int'(sz) && k < 8; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] b = 0;
    for (int k = 0; k < 8; k++) if (m[k]) b[8*k +: 8] = 8'hFF;
    return b;
  endfunction

  function automatic bit m_elig();
`ifdef DCWBUF_MERGE_EN
    return sbcache && mq.size() >= 2 && mq[mq.size()-1].cache && mq[mq.size()-1].dw == sbpa[31:3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return !sbflush && (mq.size() < DEPTH || m_elig());
  endfunction

  function automatic void m_lookup(output bit hit, output bit conf, output logic [63:0] data);
    bit [7:0] req, cov;
    bit nc;
    req = lanes(ldpa[2:0], ldsz);
    cov = 0;
    nc = 0;
    data = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].dw == ldpa[31:3] && mq[i].mask[k]) begin
          data[8*k +: 8] = mq[i].data[8*k +: 8];
          cov[k] = 1'b1;
          break;
        end
      end
    end
    foreach (mq[i]) if (mq[i].dw == ldpa[31:3] && !mq[i].cache) nc = 1'b1;
    hit  = ldvalid && ldcache && ((req & ~cov) == 0);
    conf = ldvalid && ((((req & cov) != 0) && ((req & ~cov) != 0))
           || (!ldcache && mq.size() != 0) || nc);
    if (!ldvalid) data = 0;
  endfunction

  // Reference model state update on each clock edge.
  always @(posedge clk) begin
    if (rst_n) begin
      bit acc, elig;
      ent_t e;
      elig = m_elig();
      acc  = sbvalid && m_ready();
      if (mq.size() != 0 && !dcbusy) void'(mq.pop_front());
      if (acc) begin
        e.dw    = sbpa[31:3];
        e.mask  = lanes(sbpa[2:0], sbsz);
        e.data  = sbdata & expand(e.mask);
        e.cache = sbcache;
        if (elig) begin
          mq[mq.size()-1].mask = mq[mq.size()-1].mask | e.mask;
          mq[mq.size()-1].data = (mq[mq.size()-1].data & ~expand(e.mask)) | e.data;
          sbq[sbq.size()-1] = mq[mq.size()-1];
        end else begin
          mq.push_back(e);
          sbq.push_back(e);
        end
      end
    end
  end

  // Monitor: compare status and lookup every cycle, pop expected writes as the cache takes them.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      bit h, c;
      logic [63:0] d;
      chk("sbcount", 64'(sbcount), 64'(mq.size()));
      chk("sbempty", 64'(sbempty), 64'(mq.size() == 0));
      chk("sbready", 64'(sbready), 64'(m_ready()));
      chk("dcwrite", 64'(dcwrite), 64'(mq.size() != 0));
      if (dcwrite) begin
        if (sbq.size() == 0) begin
          chk("drain_unexpected", 64'(1), 64'(0));
        end else begin
          chk("dcpa", 64'(dcpa), 64'({sbq[0].dw, 3'b000}));
          chk("dcwdata", dcwdata, sbq[0].data);
          chk("dcmask", 64'(dcmask), 64'(sbq[0].mask));
          chk("dccache", 64'(dccache), 64'(sbq[0].cache));
          if (!dcbusy) void'(sbq.pop_front());
        end
      end
      m_lookup(h, c, d);
      chk("ldhit", 64'(ldhit), 64'(h));
      chk("ldconflict", 64'(ldconflict), 64'(c));
      chk("lddata", lddata, d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] pa, input logic [2:0] sz, input logic [63:0] d);
    sbvalid = 1; sbpa = pa; sbsz = sz; sbdata = d; sbcache = 1;
    tick();
    sbvalid = 0;
  endtask

  task automatic idle();
    sbvalid = 0; sbpa = 0; sbsz = 0; sbdata = 0; sbcache = 1; dcbusy = 0;
    ldvalid = 0; ldpa = 0; ldsz = 0; ldcache = 1; sbflush = 0;
  endtask

  initial begin
    int flush_left;
    idle();
    #2 rst_n = 0;
    #1;
    chk("rst_sbcount", 64'(sbcount), 0);
    chk("rst_sbempty", 64'(sbempty), 1);
    chk("rst_sbready", 64'(sbready), 1);
    chk("rst_dcwrite", 64'(dcwrite), 0);
    chk("rst_dcmask", 64'(dcmask), 0);
    chk("rst_ldhit", 64'(ldhit), 0);
    chk("rst_ldconflict", 64'(ldconflict), 0);
    chk("rst_lddata", lddata, 0);
    @(posedge clk);
    #2 rst_n = 1;
    mon_en = 1;
    tick();

    // Single store drains one cycle after enqueue.
    store(32'h100, 3'd7, 64'h1122334455667788);
    @(negedge clk);
    chk("t1_dcwrite", 64'(dcwrite), 1);
    chk("t1_dcmask", 64'(dcmask), 64'hFF);
    chk("t1_dcpa", 64'(dcpa), 64'h100);
    chk("t1_dcwdata", dcwdata, 64'h1122334455667788);
    tick();
    @(negedge clk);
    chk("t1_empty", 64'(sbempty), 1);
    tick();

    // Fill while busy, try a store while full and popping, then drain with wrap.
    dcbusy = 1;
    for (int i = 0; i < DEPTH; i++) store(32'h140 + 32'(8 * i), 3'd7, {$urandom, $urandom});
    @(negedge clk);
    chk("t2_sbready", 64'(sbready), 0);
    chk("t2_sbcount", 64'(sbcount), 64'(DEPTH));
    tick();
    dcbusy = 0;
    store(32'h160, 3'd7, 64'hDEAD);
    repeat (DEPTH) tick();
    @(negedge clk);
    chk("t2_empty", 64'(sbempty), 1);
    tick();

    // Byte store forwarding and partial overlap.
    dcbusy = 1;
    store(32'h203, 3'd0, 64'h00000000AB000000);
    ldvalid = 1; ldpa = 32'h203; ldsz = 0; ldcache = 1;
    @(negedge clk);
    chk("t3_ldhit", 64'(ldhit), 1);
    chk("t3_lane3", 64'(lddata[31:24]), 64'hAB);
    tick();
    ldpa = 32'h200; ldsz = 3;
    @(negedge clk);
    chk("t3_conflict", 64'(ldconflict), 1);
    chk("t3_nohit", 64'(ldhit), 0);
    tick();
    ldvalid = 0;

    // Youngest writer wins; uncached load against a non-empty buffer.
    store(32'h300, 3'd0, 64'h11);
    store(32'h300, 3'd0, 64'h22);
    ldvalid = 1; ldpa = 32'h300; ldsz = 0; ldcache = 1;
    @(negedge clk);
    chk("t4_young", 64'(lddata[7:0]), 64'h22);
    tick();
    ldpa = 32'h400; ldcache = 0;
    @(negedge clk);
    chk("t4_uncached", 64'(ldconflict), 1);
    tick();
    ldvalid = 0; ldcache = 1; dcbusy = 0;
    repeat (DEPTH + 1) tick();

    // Merge of adjacent stores to the same doubleword.
    dcbusy = 1;
    store(32'h500, 3'd0, 64'h5A);
    store(32'h508, 3'd0, 64'h01);
    store(32'h509, 3'd0, 64'h0200);
    @(negedge clk);
`ifdef DCWBUF_MERGE_EN
    chk("t5_count", 64'(sbcount), 2);
`else
    chk("t5_count", 64'(sbcount), 3);
`endif
    tick();
    dcbusy = 0;
    tick();
    dcbusy = 1;
    @(negedge clk);
    chk("t5_dcpa", 64'(dcpa), 64'h508);
`ifdef DCWBUF_MERGE_EN
    chk("t5_mask", 64'(dcmask), 64'h03);
`else
    chk("t5_mask", 64'(dcmask), 64'h01);
`endif
    tick();
    dcbusy = 0;
    repeat (DEPTH) tick();

    // Flush blocks enqueue until the buffer is empty.
    dcbusy = 1;
    store(32'h600, 3'd1, 64'h3344);
    store(32'h608, 3'd1, 64'h5566);
    sbflush = 1; sbvalid = 1; sbpa = 32'h610; sbsz = 0; dcbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_flush_ready", 64'(sbready), 0);
      if (sbempty) break;
      tick();
    end
    chk("t6_flush_empty", 64'(sbempty), 1);
    tick();
    sbflush = 0; sbvalid = 0;

    // Randomized traffic.
    flush_left = 0;
    for (int n = 0; n < 800; n++) begin
      sbvalid = ($urandom_range(0, 2) != 0);
      sbpa    = ((32'h20 + $urandom_range(0, 5)) << 3) | 32'($urandom_range(0, 7));
      sbsz    = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      sbdata  = {$urandom, $urandom};
      sbcache = ($urandom_range(0, 7) != 0);
      dcbusy  = ($urandom_range(0, 2) == 0);
      ldvalid = ($urandom_range(0, 1) != 0);
      ldpa    = ((32'h20 + $urandom_range(0, 5)) << 3) | 32'($urandom_range(0, 7));
      ldsz    = 3'($urandom_range(0, 7));
      ldcache = ($urandom_range(0, 5) != 0);
      if (flush_left > 0) begin
        flush_left--;
        if (mq.size() == 0) flush_left = 0;
      end else if ($urandom_range(0, 49) == 0) begin
        flush_left = 30;
      end
      sbflush = (flush_left > 0);
      tick();
    end

    // Reset in the middle of a drain.
    idle();
    dcbusy = 1;
    store(32'h700, 3'd7, 64'h77);
    store(32'h708, 3'd7, 64'h88);
    store(32'h710, 3'd7, 64'h99);
    dcbusy = 0;
    tick();
    #2 rst_n = 0;
    mq.delete();
    sbq.delete();
    #1;
    chk("mid_rst_count", 64'(sbcount), 0);
    chk("mid_rst_dcwrite", 64'(dcwrite), 0);
    chk("mid_rst_empty", 64'(sbempty), 1);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
